// File: rtl/uart_tx_frame_serializer_if.sv
// Word handshake and per-frame line settings
// between the TX FIFO and the serializer.
interface uart_tx_frame_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        par_mode;
  logic              stop2;

  modport master (
    output in_data,
    output in_valid,
    output par_mode,
    output stop2,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  par_mode,
    input  stop2,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_frame_serializer.sv
// UART TX serializer: start, LSB-first data,
// optional parity, 1 or 2 stop bits.
module uart_tx_frame_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic reg_clk,
  input  logic reg_rst,
  uart_tx_frame_serializer_if.slave s_if,
  output logic serial_out,
  output logic busy,
  output logic frame_done
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nx;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_nx;
  logic               r_par;
  logic               w_par_ld;
  logic               r_has_par;
  logic               r_stop2;
  logic               r_stop;
  logic               w_stop_nx;
  logic               r_tx;
  logic               w_tx_nx;
  logic               r_done;
  logic               w_done_nx;
  logic               w_load;
  logic               w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Parity value captured alongside the word
  always_comb begin
    w_par_ld = 1'b0;
    unique case (s_if.par_mode)
      2'b01:   w_par_ld = ^s_if.in_data;
      2'b10:   w_par_ld = ~(^s_if.in_data);
      2'b11:   w_par_ld = 1'b1;
      default: w_par_ld = 1'b0;
    endcase
  end

  // Next state, bit timing and next line level
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_stop_nx  = r_stop;
    w_tx_nx    = r_tx;
    w_done_nx  = 1'b0;
    w_load     = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_nx = w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
    unique case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (s_if.in_valid) begin
          w_load     = 1'b1;
          w_state_nx = S_START;
          w_cnt_nx   = '0;
          w_tx_nx    = 1'b0;
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_state_nx = S_DATA;
          w_idx_nx   = '0;
          w_tx_nx    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_idx == IDX_W'(DATA_W - 1)) begin
            w_stop_nx = 1'b0;
            if (r_has_par) begin
              w_state_nx = S_PARITY;
              w_tx_nx    = r_par;
            end else begin
              w_state_nx = S_STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_idx_nx   = r_idx + IDX_W'(1);
            w_shift_nx = r_shift >> 1;
            w_tx_nx    = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state_nx = S_STOP;
          w_stop_nx  = 1'b0;
          w_tx_nx    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          if (r_stop2 && !r_stop) begin
            w_stop_nx = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end
          w_tx_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Datapath and shadow registers
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_has_par <= 1'b0;
      r_stop2   <= 1'b0;
      r_stop    <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_stop  <= w_stop_nx;
      r_tx    <= w_tx_nx;
      r_done  <= w_done_nx;
      if (w_load) begin
        r_shift   <= s_if.in_data;
        r_par     <= w_par_ld;
        r_has_par <= (s_if.par_mode != 2'b00);
        r_stop2   <= s_if.stop2;
      end else begin
        r_shift <= w_shift_nx;
      end
    end
  end

  assign s_if.in_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign serial_out    = r_tx;
  assign frame_done    = r_done;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench for the UART TX serializer,
// DATA_W=8, CLKS_PER_BIT=4.
module tb_uart_tx_frame_serializer;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          nb;
    logic [7:0]  data;
  } frame_t;

  logic clk = 1'b0;
  logic reg_rst;
  logic serial_out;
  logic busy;
  logic frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  frame_t sb_q[$];
  frame_t cur;
  bit     in_frame = 0;
  int     cyc      = 0;
  bit     bad      = 0;
  logic   bad_val  = 1'b0;
  int     idle_cnt = 0;
  int     last_gap = -1;

  uart_tx_frame_serializer_if #(.DATA_W(8)) bus ();

  uart_tx_frame_serializer #(
    .DATA_W(8),
    .CLKS_PER_BIT(CPB),
    .CNT_W(4)
  ) dut (
    .reg_clk(clk),
    .reg_rst(reg_rst),
    .s_if(bus),
    .serial_out(serial_out),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pe is the hand-computed parity bit for this word and mode
  task automatic send(input logic [7:0] d, input logic [1:0] m,
                      input logic s2, input logic pe, input bit hold);
    frame_t f;
    int     k;
    int     n;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (m != 2'b00) begin
      f.bits[n] = pe;
      n++;
    end
    n = n + 1 + int'(s2);
    f.nb = n;
    f.data = d;
    @(negedge clk);
    bus.in_data  = d;
    bus.par_mode = m;
    bus.stop2    = s2;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      chk("handshake_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      sb_q.push_back(f);
      @(posedge clk);
      #1;
      if (!hold) bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || in_frame || busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops the expected frame at each start bit
  always @(negedge clk) begin
    if (reg_rst) begin
      in_frame = 0;
      idle_cnt = 0;
    end else begin
      if (!in_frame && serial_out == 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          cur      = sb_q.pop_front();
          in_frame = 1;
          cyc      = 0;
          bad      = 0;
          last_gap = idle_cnt;
          idle_cnt = 0;
          chk("busy_at_start", int'(busy), 1);
          chk("ready_at_start", int'(bus.in_ready), 0);
        end
      end
      if (in_frame) begin
        if (cyc < cur.nb * CPB) begin
          if (serial_out !== cur.bits[cyc/CPB]) begin
            bad     = 1;
            bad_val = serial_out;
          end
          if (frame_done) chk("stray_frame_done", 1, 0);
          if (cyc % CPB == CPB - 1) begin
            chk($sformatf("d%0h_bit%0d", cur.data, cyc/CPB),
                int'(bad ? bad_val : cur.bits[cyc/CPB]),
                int'(cur.bits[cyc/CPB]));
            bad = 0;
          end
          cyc++;
        end else begin
          chk($sformatf("d%0h_frame_done", cur.data),
              int'(frame_done), 1);
          chk($sformatf("d%0h_ready_end", cur.data),
              int'(bus.in_ready), 1);
          chk($sformatf("d%0h_line_end", cur.data),
              int'(serial_out), 1);
          in_frame = 0;
          idle_cnt = 1;
        end
      end else if (serial_out == 1'b1) begin
        if (frame_done) chk("stray_frame_done", 1, 0);
        idle_cnt++;
      end
    end
  end

  initial begin
    int bad_idle;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.par_mode = 2'b00;
    bus.stop2    = 1'b0;
    reg_rst      = 1'b1;
    repeat (3) @(negedge clk);
    #2 reg_rst = 1'b0;

    // Async reset while idle, checked before any edge
    @(negedge clk);
    #2 reg_rst = 1'b1;
    #1;
    chk("rst_line", int'(serial_out), 1);
    chk("rst_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    @(negedge clk);
    #2 reg_rst = 1'b0;

    bad_idle = 0;
    repeat (100) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) bad_idle++;
    end
    chk("idle_100", bad_idle, 0);

    // Basic frame, then parity modes
    send(8'hA5, 2'b00, 1'b0, 1'b0, 0);
    wait_idle();
    send(8'hA5, 2'b01, 1'b0, 1'b0, 0);
    wait_idle();
    send(8'hA5, 2'b10, 1'b0, 1'b1, 0);
    wait_idle();
    send(8'hA5, 2'b11, 1'b0, 1'b1, 0);
    wait_idle();
    send(8'h07, 2'b10, 1'b0, 1'b0, 0);
    wait_idle();

    // Back-to-back, two stop bits
    send(8'h00, 2'b00, 1'b1, 1'b0, 1);
    send(8'hFF, 2'b00, 1'b1, 1'b0, 0);
    wait_idle();
    chk("b2b_idle_gap", last_gap, 1);

    // Mid-frame config change and ignored valid
    send(8'hA5, 2'b01, 1'b0, 1'b0, 0);
    repeat (12) @(negedge clk);
    bus.par_mode = 2'b00;
    bus.stop2    = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Reset during the 4th data bit
    send(8'h96, 2'b00, 1'b0, 1'b0, 0);
    repeat (18) @(negedge clk);
    chk("pre_rst_line", int'(serial_out), 0);
    #2 reg_rst = 1'b1;
    #1;
    chk("midrst_line", int'(serial_out), 1);
    chk("midrst_ready", int'(bus.in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    #2 reg_rst = 1'b0;
    send(8'h5A, 2'b00, 1'b0, 1'b0, 0);
    wait_idle();
    chk("queue_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
